flexbyte_stp_packer: RTL
========================

# flexbyte_stp_packer

Parametrised serial-to-parallel byte packer. It accepts NUM_BYTES_IN bytes per beat under a valid/ready handshake and assembles NUM_BYTES_OUT-byte words in a configurable byte order. Completed words are presented on a registered valid/ready output with backpressure, and the block can optionally emit a partial word with a byte-keep mask. It sits between byte-serial receive logic and word-wide consumers such as FIFOs and register files.

## Interface
- MSB, 1: 1 = first received byte lands in the most significant position; 0 = first byte lands in the least significant position.
- NUM_BYTES_IN, 1: bytes per input beat.
- NUM_BYTES_OUT, 4: bytes per output word.
  - Must be greater than NUM_BYTES_IN and an integer multiple of it; otherwise elaboration fails with $fatal.
  - BEATS = NUM_BYTES_OUT / NUM_BYTES_IN.
  - CW = max(1, $clog2(BEATS)).
- clk  input  1  clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all state; highest priority after reset.
- in_valid  input  1  data_in holds a valid beat.
- in_ready  output  1  block accepts a beat this cycle.
- data_in  input  8*NUM_BYTES_IN  input beat.
- out_valid  output  1  data_out/out_keep hold a word.
- out_ready  input  1  consumer takes the word this cycle.
- data_out  output  8*NUM_BYTES_OUT  assembled word (registered).
- out_keep  output  NUM_BYTES_OUT  per-byte valid mask (registered).
- beat_count  output  CW  beats currently held in the accumulator (0..BEATS-1).
- flush  input  1  present only with FLEXBYTE_STP_PACKER_FLUSH_EN.

## Operation
- Reset value of every output:
  - in_ready: combinational, so it reads 1 while n_rst is low.
  - out_valid 0, data_out 0, out_keep 0, beat_count 0; accumulator 0.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = (beat_count != BEATS-1) || !out_valid || out_ready.
  - in_ready depends combinationally on out_ready.
  - in_ready depends on no other input.
- Storing an accepted beat:
  - MSB=1: acc_next = (acc << 8*NUM_BYTES_IN) with data_in inserted into the low bytes.
  - MSB=0: acc_next = (acc >> 8*NUM_BYTES_IN) with data_in inserted into the high bytes.
- Completing a word: when the accepted beat is beat BEATS-1:
  - acc_next loads into data_out; out_keep becomes all ones; out_valid becomes 1.
  - beat_count returns to 0 and the accumulator is zeroed.
- Output slot:
  - out_valid clears when out_valid && out_ready, unless a new word loads in the same cycle.
  - Load and drain in the same cycle: the new word replaces the old one and out_valid stays 1, giving full throughput.
  - data_out and out_keep are stable while out_valid && !out_ready.
- beat_count wraps from BEATS-1 to 0 only on word completion; it never reaches BEATS.
- clear: zeroes the accumulator, beat_count, out_valid, data_out and out_keep; any beat offered in that cycle is dropped.

## Timing
- Latency: last beat accepted at edge N -> out_valid=1 with the word after edge N.
- Sustained rate: one beat per cycle when out_ready is held high.
- Full stall: with out_valid=1 and out_ready=0, in_ready stays 1 until beat_count=BEATS-1, then drops to 0 until out_ready=1.
- Reset mid-word: the partial word is discarded, with no output.

## Configuration
- FLEXBYTE_STP_PACKER_FLUSH_EN defined: the flush port exists.
  - Acted on in a cycle where flush=1, the effective count k (beat_count plus 1 if a beat is accepted that cycle) satisfies 0<k<BEATS, and (!out_valid || out_ready).
  - Emitted word, MSB=1: acc_next << 8*NUM_BYTES_IN*(BEATS-k); out_keep = top k*NUM_BYTES_IN bits set.
  - Emitted word, MSB=0: acc_next >> 8*NUM_BYTES_IN*(BEATS-k); out_keep = low k*NUM_BYTES_IN bits set.
  - After the flush, the accumulator and beat_count are 0.
  - If the accepted beat completes a word (k=BEATS), a normal full word is emitted.
  - If k=0, flush is ignored.
  - If the output slot is blocked, flush waits; it is level-sensitive and must be held by the requester.
- Macro undefined: no flush port, out_keep is all ones whenever out_valid=1, and no partial word is ever emitted.

## Test plan
- IN=1, OUT=4, MSB=1, out_ready=1; beats AA,BB,CC,DD on consecutive cycles -> data_out=0xAABBCCDD, out_keep=0xF, out_valid=1 for one cycle, starting the cycle after DD.
- Same stimulus with MSB=0 -> data_out=0xDDCCBBAA.
- IN=2, OUT=4, MSB=1; beats 0x1122, 0x3344 -> data_out=0x11223344; beat_count reads 0,1,0.
- Backpressure: IN=1, OUT=4, out_ready=0; send 01..08 -> first word 0x01020304 held; in_ready=0 while 08 is offered; raise out_ready -> 08 accepted that cycle, next word 0x05060708.
- Flush (macro on), MSB=1, IN=1, OUT=4; beats 11, 22 then flush=1 -> data_out=0x11220000, out_keep=0xC, beat_count=0. Flush with beat_count=0 -> no output.
- Mid-operation: after AA,BB, assert n_rst=0 for one cycle then send CC,DD,EE,FF -> word 0xCCDDEEFF. Repeat using clear instead of n_rst -> same result.

Source files
------------

// File: rtl/flexbyte_stp_packer.sv
// Serial-to-parallel byte packer: NUM_BYTES_IN-byte beats in, NUM_BYTES_OUT-byte words out.
// Define FLEXBYTE_STP_PACKER_FLUSH_EN to add the flush port for emitting partial words with a keep mask.
module flexbyte_stp_packer #(
  parameter int MSB           = 1,
  parameter int NUM_BYTES_IN  = 1,
  parameter int NUM_BYTES_OUT = 4,
  localparam int BEATS = NUM_BYTES_OUT / NUM_BYTES_IN,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*NUM_BYTES_IN-1:0]    data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8*NUM_BYTES_OUT-1:0]   data_out,
  output logic [NUM_BYTES_OUT-1:0]     out_keep,
  output logic [CW-1:0]                beat_count
`ifdef FLEXBYTE_STP_PACKER_FLUSH_EN
  ,input  logic                        flush
`endif
);

  localparam int IW = 8 * NUM_BYTES_IN;
  localparam int OW = 8 * NUM_BYTES_OUT;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [NUM_BYTES_OUT-1:0] KEEP_ALL = '1;

  if ((NUM_BYTES_OUT <= NUM_BYTES_IN) || ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0)) begin : g_bad_cfg
    $fatal(1, "flexbyte_stp_packer: NUM_BYTES_OUT must be a larger integer multiple of NUM_BYTES_IN");
  end

  logic [OW-1:0]            r_acc;
  logic [CW-1:0]            r_beat_count;
  logic                     r_out_valid;
  logic [OW-1:0]            r_data_out;
  logic [NUM_BYTES_OUT-1:0] r_keep;

  logic                     w_accept;
  logic                     w_complete;
  logic [OW-1:0]            w_acc_next;
  logic                     w_load;
  logic [OW-1:0]            w_load_word;
  logic [NUM_BYTES_OUT-1:0] w_load_keep;

  // Only a full accumulator facing a blocked output slot can refuse a beat.
  assign in_ready   = (r_beat_count != LAST) || !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (r_beat_count == LAST);
  assign w_acc_next = (MSB != 0) ? {r_acc[OW-IW-1:0], data_in} : {data_in, r_acc[OW-1:IW]};

`ifdef FLEXBYTE_STP_PACKER_FLUSH_EN
  logic [CW:0]              w_k;
  logic                     w_flush_go;
  logic [OW-1:0]            w_acc_upd;
  logic [OW-1:0]            w_flush_word;
  logic [NUM_BYTES_OUT-1:0] w_flush_keep;

  assign w_k        = {1'b0, r_beat_count} + {{CW{1'b0}}, w_accept};
  assign w_acc_upd  = w_accept ? w_acc_next : r_acc;
  // A completing beat wins over flush, so k < BEATS is implied by !w_complete.
  assign w_flush_go = flush && (w_k != '0) && !w_complete && (!r_out_valid || out_ready);

  always_comb begin
    w_flush_word = '0;
    w_flush_keep = '0;
    if (MSB != 0) begin
      w_flush_word = w_acc_upd << (IW * (BEATS - int'(w_k)));
      w_flush_keep = ~(KEEP_ALL >> (int'(w_k) * NUM_BYTES_IN));
    end else begin
      w_flush_word = w_acc_upd >> (IW * (BEATS - int'(w_k)));
      w_flush_keep = ~(KEEP_ALL << (int'(w_k) * NUM_BYTES_IN));
    end
  end

  assign w_load      = w_complete || w_flush_go;
  assign w_load_word = w_complete ? w_acc_next : w_flush_word;
  assign w_load_keep = w_complete ? KEEP_ALL : w_flush_keep;
`else
  assign w_load      = w_complete;
  assign w_load_word = w_acc_next;
  assign w_load_keep = KEEP_ALL;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc        <= '0;
      r_beat_count <= '0;
      r_out_valid  <= 1'b0;
      r_data_out   <= '0;
      r_keep       <= '0;
    end else if (clear) begin
      r_acc        <= '0;
      r_beat_count <= '0;
      r_out_valid  <= 1'b0;
      r_data_out   <= '0;
      r_keep       <= '0;
    end else begin
      if (w_load) begin
        r_acc        <= '0;
        r_beat_count <= '0;
      end else if (w_accept) begin
        r_acc        <= w_acc_next;
        r_beat_count <= r_beat_count + 1'b1;
      end
      // A new word overwrites the slot even while the old one drains.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_data_out  <= w_load_word;
        r_keep      <= w_load_keep;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign data_out   = r_data_out;
  assign out_keep   = r_keep;
  assign beat_count = r_beat_count;

endmodule
